// File: rtl/msg_pkg.sv
// Shared definitions for the message writer and the HEX scroller: character
// codes, the blank segment pattern, the editor state and the character map.
package msg_pkg;

  localparam logic [4:0] CH_0     = 5'd0;
  localparam logic [4:0] CH_1     = 5'd1;
  localparam logic [4:0] CH_2     = 5'd2;
  localparam logic [4:0] CH_3     = 5'd3;
  localparam logic [4:0] CH_4     = 5'd4;
  localparam logic [4:0] CH_5     = 5'd5;
  localparam logic [4:0] CH_6     = 5'd6;
  localparam logic [4:0] CH_7     = 5'd7;
  localparam logic [4:0] CH_8     = 5'd8;
  localparam logic [4:0] CH_9     = 5'd9;
  localparam logic [4:0] CH_A     = 5'd10;
  localparam logic [4:0] CH_B     = 5'd11;
  localparam logic [4:0] CH_C     = 5'd12;
  localparam logic [4:0] CH_D     = 5'd13;
  localparam logic [4:0] CH_E     = 5'd14;
  localparam logic [4:0] CH_F     = 5'd15;
  localparam logic [4:0] CH_G     = 5'd16;
  localparam logic [4:0] CH_H     = 5'd17;
  localparam logic [4:0] CH_I     = 5'd18;
  localparam logic [4:0] CH_J     = 5'd19;
  localparam logic [4:0] CH_L     = 5'd20;
  localparam logic [4:0] CH_N     = 5'd21;
  localparam logic [4:0] CH_O     = 5'd22;
  localparam logic [4:0] CH_P     = 5'd23;
  localparam logic [4:0] CH_R     = 5'd24;
  localparam logic [4:0] CH_S     = 5'd25;
  localparam logic [4:0] CH_U     = 5'd26;
  localparam logic [4:0] CH_Y     = 5'd27;
  localparam logic [4:0] CH_DASH  = 5'd28;
  localparam logic [4:0] CH_UNDER = 5'd29;
  localparam logic [4:0] CH_BLANK = 5'd30;
  localparam logic [4:0] CH_SPACE = 5'd31;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {EDIT, LOCKED} state_t;

  // One decoded key action per cycle after priority resolution.
  typedef enum logic [1:0] {EV_NONE, EV_WRITE, EV_BACK, EV_COMMIT} event_t;

  // Active-low segments, bit 6 = g down to bit 0 = a.
  function automatic logic [6:0] char_to_seg(input logic [4:0] code);
    case (code)
      CH_0:     return 7'h40;
      CH_1:     return 7'h79;
      CH_2:     return 7'h24;
      CH_3:     return 7'h30;
      CH_4:     return 7'h19;
      CH_5:     return 7'h12;
      CH_6:     return 7'h02;
      CH_7:     return 7'h78;
      CH_8:     return 7'h00;
      CH_9:     return 7'h10;
      CH_A:     return 7'h08;
      CH_B:     return 7'h03;
      CH_C:     return 7'h46;
      CH_D:     return 7'h21;
      CH_E:     return 7'h06;
      CH_F:     return 7'h0E;
      CH_G:     return 7'h42;
      CH_H:     return 7'h09;
      CH_I:     return 7'h4F;
      CH_J:     return 7'h61;
      CH_L:     return 7'h47;
      CH_N:     return 7'h2B;
      CH_O:     return 7'h23;
      CH_P:     return 7'h0C;
      CH_R:     return 7'h2F;
      CH_S:     return 7'h12;
      CH_U:     return 7'h41;
      CH_Y:     return 7'h11;
      CH_DASH:  return 7'h3F;
      CH_UNDER: return 7'h77;
      default:  return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/msg_entry_writer_if.sv
// Board-side bundle of the message writer: raw keys and switches in, read port
// and status/preview out.
interface msg_entry_writer_if #(
    parameter int ADDR_W = 4
);
    logic [2:0]        key_n;
    logic [4:0]        char_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [6:0]        rd_seg;
    logic [ADDR_W:0]   msg_len;
    logic              msg_valid;
    logic [ADDR_W:0]   cursor;
    logic              full;
    logic [6:0]        preview_seg;

    modport master (
        output key_n, char_sel, rd_addr,
        input  rd_seg, msg_len, msg_valid, cursor, full, preview_seg
    );

    modport slave (
        input  key_n, char_sel, rd_addr,
        output rd_seg, msg_len, msg_valid, cursor, full, preview_seg
    );
endinterface

// File: rtl/key_debounce.sv
// One push button: 2-flop synchroniser, stability counter and a single-cycle
// press pulse on an accepted release-to-press transition.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync;
    logic [1:0]       sync_vld;
    logic             level;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // A key held through reset must be seen released before it may fire, so
    // arming waits until the synchroniser carries a real sample of a high key.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync     <= 2'b11;
            sync_vld <= 2'b00;
            level    <= 1'b1;
            armed    <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values from before this edge.
            sync     <= {sync[0], key_n};
            sync_vld <= {sync_vld[0], 1'b1};
            press    <= 1'b0;
            if (sync_vld[1] && sync[1])
                armed <= 1'b1;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync[1];
                press <= ~sync[1] & armed;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/msg_entry_writer.sv
// Message composer: debounced keys drive an EDIT/LOCKED editor over a small
// character buffer that the scroller reads through a registered port.
module msg_entry_writer
    import msg_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    msg_entry_writer_if.slave bus
);
    localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);

    logic [2:0]        press;
    event_t            ev;
    state_t            state, state_nxt;
    logic [ADDR_W:0]   cursor, cursor_nxt;
    logic [ADDR_W:0]   msg_len, len_nxt;
    logic              wr_en;
    logic [4:0]        mem [DEPTH];

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .CLOCK_50 (CLOCK_50),
            .RESET    (RESET),
            .key_n    (bus.key_n[k]),
            .press    (press[k])
        );
    end

    always_comb begin
        ev = EV_NONE;
        if (press[2])      ev = EV_COMMIT;
        else if (press[1]) ev = EV_BACK;
        else if (press[0]) ev = EV_WRITE;
    end

    assign bus.full      = (cursor == LEN_FULL);
    assign bus.cursor    = cursor;
    assign bus.msg_len   = msg_len;
    assign bus.msg_valid = (state == LOCKED);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state   <= EDIT;
            cursor  <= '0;
            msg_len <= '0;
        end else begin
            state   <= state_nxt;
            cursor  <= cursor_nxt;
            msg_len <= len_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_nxt  = state;
        cursor_nxt = cursor;
        len_nxt    = msg_len;
        wr_en      = 1'b0;
        case (state)
            EDIT: begin
                case (ev)
                    EV_WRITE: begin
                        if (!bus.full) begin
                            wr_en      = 1'b1;
                            cursor_nxt = cursor + LEN_ONE;
                        end
                    end
                    EV_BACK: begin
                        if (cursor != '0)
                            cursor_nxt = cursor - LEN_ONE;
                    end
                    EV_COMMIT: begin
                        if (cursor != '0) begin
                            len_nxt   = cursor;
                            state_nxt = LOCKED;
                        end
                    end
                    default: ;
                endcase
            end
            LOCKED: begin
                if (ev == EV_COMMIT)
                    state_nxt = EDIT;
            end
            default: state_nxt = EDIT;
        endcase
    end

    // NOTE: the buffer has no reset; stale entries stay unreachable behind cursor and msg_len.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            mem[cursor[ADDR_W-1:0]] <= bus.char_sel;
    end

    // Writes only happen in EDIT, where reads are blanked, so no bypass is needed.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            bus.rd_seg      <= SEG_BLANK;
            bus.preview_seg <= SEG_BLANK;
        end else begin
            bus.preview_seg <= char_to_seg(bus.char_sel);
            if ((state == LOCKED) && ({1'b0, bus.rd_addr} < msg_len))
                bus.rd_seg <= char_to_seg(mem[bus.rd_addr]);
            else
                bus.rd_seg <= SEG_BLANK;
        end
    end
endmodule

// File: tb/tb_msg_entry_writer.sv
// Directed and randomized key sequences checked against a buffer/length model
// of the message editor.
module tb_msg_entry_writer;

    localparam int DEPTH = 16;

    // Lit segments (active-high, g..a) of each character code.
    localparam logic [6:0] GLYPH [32] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
        7'h3D, 7'h76, 7'h30, 7'h1E, 7'h38, 7'h54, 7'h5C, 7'h73,
        7'h50, 7'h6D, 7'h3E, 7'h6E, 7'h40, 7'h08, 7'h00, 7'h00
    };

    logic clock_50;
    logic reset;
    int   n_cmp;
    int   n_fail;

    // Reference model: typed text, edit length, committed length, lock flag.
    int   m_text [DEPTH];
    int   m_cur;
    int   m_len;
    bit   m_locked;

    msg_entry_writer_if #(.ADDR_W(4)) bus ();

    msg_entry_writer #(
        .DEPTH        (DEPTH),
        .ADDR_W       (4),
        .DEBOUNCE_CYC (4)
    ) dut (
        .CLOCK_50 (clock_50),
        .RESET    (reset),
        .bus      (bus)
    );

    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    function automatic logic [6:0] seg_of(input int code);
        return ~GLYPH[code];
    endfunction

    function automatic logic [6:0] model_read(input int addr);
        if (m_locked && addr < m_len) return seg_of(m_text[addr]);
        return 7'h7F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock_50);
    endtask

    task automatic model_apply(input logic [2:0] mask, input int ch);
        if (mask[2]) begin
            if (m_locked) m_locked = 1'b0;
            else if (m_cur > 0) begin
                m_len    = m_cur;
                m_locked = 1'b1;
            end
        end else if (mask[1]) begin
            if (!m_locked && m_cur > 0) m_cur--;
        end else if (mask[0]) begin
            if (!m_locked && m_cur < DEPTH) begin
                m_text[m_cur] = ch;
                m_cur++;
            end
        end
    endtask

    // Clean press of the keys in mask, long enough to debounce both edges.
    task automatic press(input logic [2:0] mask);
        bus.key_n = ~mask;
        cycles(10);
        bus.key_n = 3'b111;
        cycles(12);
        model_apply(mask, int'(bus.char_sel));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.key_n = 3'b111;
        cycles(3);
        reset     = 1'b0;
        m_cur     = 0;
        m_len     = 0;
        m_locked  = 1'b0;
        cycles(2);
    endtask

    task automatic read_check(input string tag, input int addr);
        logic [3:0] a;
        a           = addr[3:0];
        bus.rd_addr = a;
        cycles(1);
        check(tag, bus.rd_seg, model_read(addr));
    endtask

    task automatic check_status(input string tag);
        check({tag, ".cursor"}, bus.cursor, m_cur);
        check({tag, ".full"}, bus.full, (m_cur == DEPTH));
        check({tag, ".valid"}, bus.msg_valid, m_locked);
        check({tag, ".len"}, bus.msg_len, m_len);
    endtask

    initial begin
        logic [2:0] mask;
        n_cmp        = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.key_n    = 3'b111;
        bus.char_sel = 5'd0;
        bus.rd_addr  = '0;
        for (int i = 0; i < DEPTH; i++) m_text[i] = 31;

        // Reset values, sampled while reset is still applied.
        cycles(2);
        check("rst.rd_seg", bus.rd_seg, 7'h7F);
        check("rst.preview", bus.preview_seg, 7'h7F);
        check("rst.len", bus.msg_len, 0);
        check("rst.valid", bus.msg_valid, 0);
        check("rst.cursor", bus.cursor, 0);
        check("rst.full", bus.full, 0);
        do_reset();

        // First character, commit, and read-back.
        bus.char_sel = 5'd10;
        press(3'b001);
        check("a.cursor", bus.cursor, 1);
        check("a.preview", bus.preview_seg, 7'h08);
        press(3'b100);
        check_status("a.commit");
        read_check("a.rd0", 0);
        check("a.rd0_const", bus.rd_seg, 7'h08);
        read_check("a.rd1", 1);
        press(3'b100);

        // Bouncing write key produces exactly one event.
        bus.char_sel = 5'd3;
        for (int b = 0; b < 2; b++) begin
            bus.key_n[0] = 1'b0;
            cycles(2);
            bus.key_n[0] = 1'b1;
            cycles(2);
        end
        bus.key_n[0] = 1'b0;
        cycles(6);
        bus.key_n[0] = 1'b1;
        cycles(12);
        model_apply(3'b001, 3);
        check("bounce.cursor", bus.cursor, 2);
        check_status("bounce");

        // Fill to capacity, overflow write, read every slot, then backspace.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus.char_sel = 5'($urandom_range(0, 31));
            press(3'b001);
        end
        check("fill.cursor", bus.cursor, 16);
        check("fill.full", bus.full, 1);
        press(3'b100);
        check_status("fill.commit");
        for (int i = 0; i < DEPTH; i++) read_check($sformatf("fill.rd%0d", i), i);
        press(3'b100);
        press(3'b010);
        check("fill.bs_cursor", bus.cursor, 15);
        check("fill.bs_full", bus.full, 0);

        // Backspace and commit on an empty buffer are ignored.
        do_reset();
        press(3'b010);
        check("empty.bs", bus.cursor, 0);
        press(3'b100);
        check("empty.commit_valid", bus.msg_valid, 0);
        bus.char_sel = 5'd21;
        press(3'b001);
        check("empty.still_edit", bus.cursor, 1);

        // Simultaneous write+commit: commit wins; locked edits ignored.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.char_sel = 5'(12 + i);
            press(3'b001);
        end
        bus.char_sel = 5'd7;
        press(3'b101);
        check("prio.len", bus.msg_len, 3);
        check_status("prio");
        for (int i = 0; i < 4; i++) read_check($sformatf("prio.rd%0d", i), i);
        press(3'b001);
        press(3'b010);
        check_status("locked.edit");
        press(3'b100);
        check("unlock.valid", bus.msg_valid, 0);
        check("unlock.cursor", bus.cursor, 3);
        check("unlock.len", bus.msg_len, 3);
        read_check("unlock.rd0", 0);

        // Reset in the middle of a debounce with the key held through release.
        bus.char_sel = 5'd31;
        bus.key_n[0] = 1'b0;
        cycles(4);
        reset = 1'b1;
        cycles(2);
        check("midrst.cursor_in", bus.cursor, 0);
        reset    = 1'b0;
        m_cur    = 0;
        m_len    = 0;
        m_locked = 1'b0;
        cycles(20);
        check("midrst.cursor", bus.cursor, 0);
        check("midrst.valid", bus.msg_valid, 0);
        check("midrst.len", bus.msg_len, 0);
        check("midrst.full", bus.full, 0);
        check("midrst.rd_seg", bus.rd_seg, 7'h7F);
        check("midrst.preview", bus.preview_seg, 7'h7F);
        bus.key_n[0] = 1'b1;
        cycles(12);
        check("midrst.release", bus.cursor, 0);
        press(3'b001);
        check("midrst.repress", bus.cursor, 1);

        // Random key mixes against the model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            bus.char_sel = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) != 0) mask = 3'b001;
            else mask = 3'($urandom_range(1, 7));
            press(mask);
            check_status($sformatf("rnd%0d", n));
            check($sformatf("rnd%0d.preview", n), bus.preview_seg, seg_of(int'(bus.char_sel)));
            read_check($sformatf("rnd%0d.rd", n), $urandom_range(0, DEPTH - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
